// File: rtl/pu_shift_seq.sv
// Command sequencer for pu_shift: one valid/ready command in, init/shift/oe strobes out,
// captured result back over valid/ready. Define PU_SHIFT_SEQ_STEP4_EN to use 4-bit step shifts.
module pu_shift_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [ATTR_WIDTH-1:0] cmd_attr,
  input  logic                  cmd_dir,
  input  logic                  cmd_mode,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [ATTR_WIDTH-1:0] res_attr,
  output logic                  signal_work,
  output logic                  signal_direction,
  output logic                  signal_mode,
  output logic                  signal_step,
  output logic                  signal_init,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] pu_data_in,
  output logic [ATTR_WIDTH-1:0] pu_attr_in,
  input  logic [DATA_WIDTH-1:0] pu_data_out,
  input  logic [ATTR_WIDTH-1:0] pu_attr_out
);

`ifdef PU_SHIFT_SEQ_STEP4_EN
  localparam bit STEP4 = 1'b1;
`else
  localparam bit STEP4 = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, INIT, SHIFT, OE, CAP, RESP} state_t;

  state_t               state;
  logic                 dir_q, mode_q, step_q;
  logic [CNT_WIDTH-1:0] rem, dec, rem_next;

  // step_q reflects the strobe being driven this cycle, so it also picks the decrement.
  always_comb begin
    dec      = (STEP4 && step_q) ? CNT_WIDTH'(4) : CNT_WIDTH'(1);
    rem_next = rem - dec;
  end

  assign signal_step = step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cmd_ready        <= 1'b0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      res_attr         <= '0;
      signal_work      <= 1'b0;
      signal_direction <= 1'b0;
      signal_mode      <= 1'b0;
      step_q           <= 1'b0;
      signal_init      <= 1'b0;
      signal_oe        <= 1'b0;
      pu_data_in       <= '0;
      pu_attr_in       <= '0;
      dir_q            <= 1'b0;
      mode_q           <= 1'b0;
      rem              <= '0;
    end else begin
      signal_init      <= 1'b0;
      signal_work      <= 1'b0;
      signal_oe        <= 1'b0;
      signal_direction <= 1'b0;
      signal_mode      <= 1'b0;
      step_q           <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            pu_data_in  <= cmd_data;
            pu_attr_in  <= cmd_attr;
            dir_q       <= cmd_dir;
            mode_q      <= cmd_mode;
            rem         <= cmd_count;
            signal_init <= 1'b1;
            state       <= INIT;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        INIT: begin
          if (rem == '0) begin
            signal_oe <= 1'b1;
            state     <= OE;
          end else begin
            signal_work      <= 1'b1;
            signal_direction <= dir_q;
            signal_mode      <= mode_q;
            step_q           <= STEP4 && (rem >= CNT_WIDTH'(4));
            state            <= SHIFT;
          end
        end
        SHIFT: begin
          rem <= rem_next;
          if (rem_next == '0) begin
            signal_oe <= 1'b1;
            state     <= OE;
          end else begin
            signal_work      <= 1'b1;
            signal_direction <= dir_q;
            signal_mode      <= mode_q;
            step_q           <= STEP4 && (rem_next >= CNT_WIDTH'(4));
          end
        end
        OE: state <= CAP;
        // pu_shift presents its result the cycle after signal_oe
        CAP: begin
          res_data  <= pu_data_out;
          res_attr  <= pu_attr_out;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_shift_seq.sv
// Bench for pu_shift_seq: behavioural pu_shift model downstream, result scoreboard, latency checks.
module tb_pu_shift_seq;
  localparam int DW = 32, AW = 4, CW = 5;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [DW-1:0] cmd_data = '0;
  logic [AW-1:0] cmd_attr = '0;
  logic          cmd_dir = 1'b0, cmd_mode = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_attr;
  logic          signal_work, signal_direction, signal_mode, signal_step, signal_init, signal_oe;
  logic [DW-1:0] pu_data_in, pu_data_out;
  logic [AW-1:0] pu_attr_in, pu_attr_out;

  pu_shift_seq #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_attr(cmd_attr),
    .cmd_dir(cmd_dir), .cmd_mode(cmd_mode), .cmd_count(cmd_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_attr(res_attr),
    .signal_work(signal_work), .signal_direction(signal_direction), .signal_mode(signal_mode),
    .signal_step(signal_step), .signal_init(signal_init), .signal_oe(signal_oe),
    .pu_data_in(pu_data_in), .pu_attr_in(pu_attr_in),
    .pu_data_out(pu_data_out), .pu_attr_out(pu_attr_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] d; logic [AW-1:0] a; } res_t;
  res_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int work_tot = 0, step_tot = 0, plain_tot = 0, excl_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (signal_work && signal_step) step_tot++;
      if (signal_work && !signal_step) plain_tot++;
      if (signal_work) work_tot++;
      if ((signal_init && signal_work) || (signal_init && signal_oe) || (signal_work && signal_oe))
        excl_viol++;
    end
  end

  // pu_shift behavioural model
  logic [DW-1:0] sh_q;
  logic [AW-1:0] sa_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0; sa_q <= '0; pu_data_out <= '0; pu_attr_out <= '0;
    end else begin
      if (signal_init) begin
        sh_q <= pu_data_in; sa_q <= pu_attr_in;
      end else if (signal_work) begin
        if (signal_direction) sh_q <= sh_q << (signal_step ? 4 : 1);
        else if (signal_mode) sh_q <= $signed(sh_q) >>> (signal_step ? 4 : 1);
        else sh_q <= sh_q >> (signal_step ? 4 : 1);
      end
      if (signal_oe) begin
        pu_data_out <= sh_q; pu_attr_out <= sa_q;
      end
    end
  end

  task automatic drive_cmd(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic dir,
                           input logic mode, input logic [CW-1:0] n, input logic [DW-1:0] ed,
                           output int acc);
    @(negedge clk);
    cmd_data = d; cmd_attr = a; cmd_dir = dir; cmd_mode = mode; cmd_count = n; cmd_valid = 1'b1;
    sb.push_back('{ed, a});
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready never seen for data %h", d);
    end
  endtask

  task automatic wait_res(input string name, input int acc, input int exp_lat, input int hold);
    int lat = -1;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    res_t e;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin
        lat = cyc - acc + 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: res_valid in cycle %0d, expected %0d", name, lat, exp_lat);
    end
    if (lat < 0) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if ({signal_init, signal_work, signal_oe, signal_step, signal_direction, signal_mode} !== 6'b0) begin
      errors++;
      $display("FAIL %s_resp_strobes: signals %b, expected 000000", name,
               {signal_init, signal_work, signal_oe, signal_step, signal_direction, signal_mode});
    end
    d = res_data; a = res_attr;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== d || res_attr !== a || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold: valid %b data %h attr %h cmd_ready %b, expected 1 %h %h 0",
                 name, res_valid, res_data, res_attr, cmd_ready, d, a);
      end
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (res_data !== e.d) begin
        errors++;
        $display("FAIL %s_data: got %h, expected %h", name, res_data, e.d);
      end
      checks++;
      if (res_attr !== e.a) begin
        errors++;
        $display("FAIL %s_attr: got %h, expected %h", name, res_attr, e.a);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_post_handshake: res_valid %b cmd_ready %b, expected 0 1", name, res_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, res_valid, res_data, res_attr, signal_work, signal_direction, signal_mode,
         signal_step, signal_init, signal_oe, pu_data_in, pu_attr_in} !== '0) begin
      errors++;
      $display("FAIL reset_values: cmd_ready %b res_valid %b res_data %h pu_data_in %h, expected all 0",
               cmd_ready, res_valid, res_data, pu_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: cmd_ready %b, expected 1", cmd_ready);
    end
  endtask

  task automatic test_left();
    int acc, w0;
    w0 = work_tot;
    drive_cmd(32'h10, 4'h1, 1'b1, 1'b1, 5'd1, 32'h20, acc);
    wait_res("left1", acc, 5, 0);
    checks++;
    if (work_tot - w0 != 1) begin
      errors++;
      $display("FAIL left1_work_pulses: %0d, expected 1", work_tot - w0);
    end
  endtask

  task automatic test_right();
    int acc;
    drive_cmd(32'h20, 4'h2, 1'b0, 1'b1, 5'd3, 32'h04, acc);
    wait_res("right_arith3", acc, 7, 0);
    drive_cmd(32'hFFFFFFF0, 4'h5, 1'b0, 1'b1, 5'd1, 32'hFFFFFFF8, acc);
    wait_res("right_arith1_neg", acc, 5, 0);
    drive_cmd(32'hFFFFFFF0, 4'h6, 1'b0, 1'b0, 5'd4, 32'h0FFFFFFF, acc);
    wait_res("right_logic4", acc, 8, 0);
  endtask

  task automatic test_count0();
    int acc, w0;
    w0 = work_tot;
    drive_cmd(32'hA5A5A5A5, 4'h3, 1'b1, 1'b0, 5'd0, 32'hA5A5A5A5, acc);
    wait_res("count0", acc, 4, 5);
    checks++;
    if (work_tot - w0 != 0) begin
      errors++;
      $display("FAIL count0_work_pulses: %0d, expected 0", work_tot - w0);
    end
    checks++;
    if (pu_data_in !== 32'hA5A5A5A5 || pu_attr_in !== 4'h3) begin
      errors++;
      $display("FAIL count0_pu_in_hold: %h/%h, expected a5a5a5a5/3", pu_data_in, pu_attr_in);
    end
  endtask

  task automatic test_step();
    int acc, s0, p0;
    s0 = step_tot; p0 = plain_tot;
    drive_cmd(32'h1, 4'h7, 1'b1, 1'b0, 5'd9, 32'h200, acc);
`ifdef PU_SHIFT_SEQ_STEP4_EN
    wait_res("step9", acc, 7, 0);
    checks++;
    if (step_tot - s0 != 2 || plain_tot - p0 != 1) begin
      errors++;
      $display("FAIL step9_cycles: step %0d plain %0d, expected 2 1", step_tot - s0, plain_tot - p0);
    end
`else
    wait_res("step9", acc, 13, 0);
    checks++;
    if (step_tot - s0 != 0 || plain_tot - p0 != 9) begin
      errors++;
      $display("FAIL step9_cycles: step %0d plain %0d, expected 0 9", step_tot - s0, plain_tot - p0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int acc1, acc2 = -1;
    res_t e;
    res_ready = 1'b1;
    drive_cmd(32'h0000_1234, 4'hA, 1'b1, 1'b0, 5'd2, 32'h0000_48D0, acc1);
    cmd_data = 32'h3; cmd_attr = 4'hB; cmd_dir = 1'b1; cmd_mode = 1'b0; cmd_count = 5'd5;
    cmd_valid = 1'b1;
    sb.push_back('{32'h60, 4'hB});
    for (int i = 0; i < 100; i++) begin
      if (res_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (res_data !== e.d || res_attr !== e.a) begin
          errors++;
          $display("FAIL b2b_first: got %h/%h, expected %h/%h", res_data, res_attr, e.d, e.a);
        end
      end
      if (cmd_ready) begin
        @(negedge clk);
        acc2 = cyc;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (acc2 - acc1 != 7) begin
      errors++;
      $display("FAIL b2b_spacing: %0d cycles between accepts, expected 7", acc2 - acc1);
    end
    wait_res("b2b_second", acc2, 9, 0);
  endtask

  task automatic test_reset_mid();
    int acc;
    drive_cmd(32'h0F00, 4'h4, 1'b0, 1'b0, 5'd8, 32'h0F, acc);
    repeat (2) @(negedge clk);
    checks++;
    if (signal_work !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_shift: signal_work %b, expected 1", signal_work);
    end
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({cmd_ready, res_valid, res_data, res_attr, signal_work, signal_direction, signal_mode,
         signal_step, signal_init, signal_oe, pu_data_in, pu_attr_in} !== '0) begin
      errors++;
      $display("FAIL midreset_values: cmd_ready %b work %b pu_data_in %h, expected all 0",
               cmd_ready, signal_work, pu_data_in);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_no_result: res_valid %b cmd_ready %b, expected 0 1", res_valid, cmd_ready);
      end
    end
    drive_cmd(32'h80000000, 4'h9, 1'b0, 1'b1, 5'd4, 32'hF8000000, acc);
    wait_res("after_reset", acc, 8, 0);
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_count0();
    test_step();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (excl_viol != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: %0d cycles with overlapping strobes, expected 0", excl_viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_shift_seq.md
# pu_shift_seq

Command sequencer sitting directly upstream of `pu_shift`: accepts one shift command (operand, attribute, direction, mode, bit count) over a valid/ready handshake and drives the `pu_shift` control lines. It issues one init cycle, the required shift cycles and one output-enable cycle, then captures the `pu_shift` result and returns it over a second valid/ready handshake. This lets upstream logic request an N-bit shift as one transaction instead of hand-sequencing `signal_*` strobes.

## Interface
- `DATA_WIDTH`, 32: operand/result width; must match `pu_shift`.
- `ATTR_WIDTH`, 4: attribute width; must match `pu_shift`.
- `CNT_WIDTH`, 5: shift-count width; legal counts are 0..DATA_WIDTH-1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_data`  in  DATA_WIDTH  operand.
- `cmd_attr`  in  ATTR_WIDTH  operand attribute.
- `cmd_dir`  in  1  1 = left, 0 = right.
- `cmd_mode`  in  1  1 = arithmetic, 0 = logical.
- `cmd_count`  in  CNT_WIDTH  number of bit positions to shift.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  DATA_WIDTH  shifted value.
- `res_attr`  out  ATTR_WIDTH  attribute returned by `pu_shift`.
- `signal_work`, `signal_direction`, `signal_mode`, `signal_step`, `signal_init`, `signal_oe`  out  1 each  to `pu_shift`.
- `pu_data_in`  out  DATA_WIDTH; `pu_attr_in`  out  ATTR_WIDTH  to `pu_shift` inputs.
- `pu_data_out`  in  DATA_WIDTH; `pu_attr_out`  in  ATTR_WIDTH  from `pu_shift` outputs.

## Operation
- States: IDLE, INIT, SHIFT, OE, CAP, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch all `cmd_*` fields and go to INIT.
- INIT (1 cycle): `signal_init`=1, `pu_data_in`/`pu_attr_in` = latched operand/attr. If count==0, go to OE; otherwise go to SHIFT with remaining=count.
- SHIFT: `signal_work`=1, `signal_direction`=latched dir, `signal_mode`=latched mode, `signal_step`=0. Decrement remaining by 1 per cycle; leave for OE when remaining reaches 0.
- OE (1 cycle): `signal_oe`=1; go to CAP.
- CAP (1 cycle): all `signal_*`=0. At the end of the cycle, register `pu_data_out`/`pu_attr_out` into `res_data`/`res_attr`; go to RESP.
- RESP: `res_valid`=1. `res_data`/`res_attr` hold stable until `res_valid && res_ready`, then go to IDLE.
- Outside the states named above, every `signal_*` is 0. At most one of `signal_init`/`signal_work`/`signal_oe` is high in any cycle.
- `pu_data_in`/`pu_attr_in` hold the latched operand from INIT until the next accept.
- cmd_count ≥ DATA_WIDTH is not legal. The block still executes it literally (count cycles); no error is flagged.

## Timing
- Handshake edge = cycle 0. INIT = cycle 1. SHIFT = cycles 2..n+1. OE = cycle n+2. CAP = cycle n+3. `res_valid` rises in cycle n+4.
- `pu_shift` drives `pu_data_out` valid in the cycle after `signal_oe` is sampled.
- `cmd_ready` is registered: 0 during reset, 1 from the first edge after `rst_n` rises, 0 from the accept edge until the cycle after the result handshake.
- No command is accepted in the same cycle as a result handshake. Back-to-back throughput is n+5 cycles.
- Reset values: `cmd_ready`=0, `res_valid`=0, `res_data`=0, `res_attr`=0, all `signal_*`=0, `pu_data_in`=0, `pu_attr_in`=0, state=IDLE.
- Reset asserted mid-operation aborts the command immediately. No result is emitted, and `pu_shift` is left unloaded.

## Configuration
- `PU_SHIFT_SEQ_STEP4_EN` defined: in SHIFT, while remaining ≥ 4, drive `signal_step`=1 (4-bit shift in `pu_shift`) and decrement by 4. The remainder uses `signal_step`=0. SHIFT length becomes floor(n/4) + n%4 cycles.
- Not defined: `signal_step` is tied to 0 and SHIFT lasts n cycles.

## Test plan
- 0x10, left, arithmetic, count 1 → `res_data`=0x20; `res_valid` in cycle 5; exactly one `signal_work` pulse.
- 0x20, right, arithmetic, count 3 → 0x04; `res_valid` in cycle 7.
- 0xFFFFFFF0, right, arithmetic, count 1 → 0xFFFFFFF8. Same operand, right, logical, count 4 → 0x0FFFFFFF.
- Count 0, operand 0xA5A5A5A5, attr 0x3 → `res_data`=0xA5A5A5A5, `res_attr`=0x3, no `signal_work`, `res_valid` in cycle 4. Hold `res_ready`=0 for 5 cycles: outputs stay stable and `cmd_ready` stays 0.
- Pull `rst_n` low during the second SHIFT cycle of a count-8 command → all outputs go to reset values immediately. After release, a new command completes correctly.
- With `PU_SHIFT_SEQ_STEP4_EN` defined, 0x1 left logical count 9 → 0x200, with 2 `signal_step`=1 cycles and 1 `signal_step`=0 cycle.
